adxl362_spi_master: RTL and testbench
=====================================

# adxl362_spi_master

SPI master for the ADXL362 accelerometer on the PmodACL2. It sits directly downstream of the clock divider: the divider's square wave arrives on `div_clk` and is edge-detected in the `in_clk` domain. Each edge becomes a one-cycle strobe that paces SCLK. The block runs single-register writes and 1–15-byte burst reads (SPI mode 0, MSB first) for the gesture-glove sampling logic.

## Interface
Parameters:
- `MAX_BYTES`, 15: upper limit on the number of data bytes in a burst read; `nbytes` is 4 bits wide.

Ports:
- `in_clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `div_clk`  in  1  divider output, synchronous to `in_clk`, period `cnt_val` cycles.
- `start`  in  1  request a transaction; sampled only in IDLE.
- `rw`  in  1  1 = read (command 0x0B), 0 = write (command 0x0A).
- `addr`  in  8  register address.
- `wdata`  in  8  write data byte.
- `nbytes`  in  4  data bytes for a read; 0 is treated as 1; ignored for writes, which are always 1 byte.
- `busy`  out  1  high from the cycle after `start` is accepted until IDLE.
- `done`  out  1  one-cycle pulse at transaction end.
- `rdata`  out  8  last received byte.
- `rdata_valid`  out  1  one-cycle pulse for each received byte.
- `sclk`  out  1  SPI clock; CPOL = 0.
- `mosi`  out  1  SPI data out.
- `miso`  in  1  SPI data in.
- `cs_n`  out  1  chip select, active low.

## Operation
- Edge strobes: register `div_clk` as `div_q`.
  - `rise = div_clk & ~div_q`.
  - `fall = ~div_clk & div_q`.
- Latched at `start` acceptance: `rw`, `addr`, `wdata`, `nbytes`.
- Frame: command byte, then address byte, then N data bytes.
  - Writes: N = 1, and `wdata` is shifted out.
  - Reads: N = max(`nbytes`, 1), and `mosi` = 0 during the data bytes.
- States and transitions:
  - IDLE: `cs_n` = 1, `sclk` = 0. On `start`, go to SETUP and load the shift register with the command byte.
  - SETUP: `cs_n` = 0, `mosi` = command bit 7. Wait for one `fall`, then go to SHIFT. This gives at least half an SCLK period of CS setup.
  - SHIFT:
    - On `rise`: `sclk` <= 1; sample `miso` into the receive shift register.
    - On `fall`: `sclk` <= 0; advance the bit counter (3 bits) and present the next bit on `mosi`.
    - After bit 0 of a byte, load the next byte (address, write data, or 0x00) and advance the byte counter.
    - The `fall` after the last bit of the last byte goes to HOLD.
  - HOLD: `sclk` = 0. Wait for one `rise`, then `cs_n` <= 1, `done` pulses, go to GAP.
  - GAP: `cs_n` = 1. Wait for one `fall`, then go to IDLE with `busy` = 0. This guarantees CS high time between frames.
- Read data: in the cycle after the `rise` that samples bit 0 of a data byte, `rdata` is updated and `rdata_valid` pulses. Command and address bytes never assert `rdata_valid`.
- `start` while `busy` = 1 is ignored; nothing is queued.
- Reset at any point: all state returns to IDLE on the next `in_clk` edge. The frame is abandoned with no `done` pulse.

## Timing
- Reset values: `cs_n` = 1, `sclk` = 0, `mosi` = 0, `busy` = 0, `done` = 0, `rdata` = 0x00, `rdata_valid` = 0.
- `cs_n` falls and `busy` rises in the cycle after `start` is accepted.
- `sclk` lags `div_clk` by exactly one `in_clk` cycle while in SHIFT; SCLK period is `cnt_val`.
- A frame has 8·(2+N) SCLK rising edges. No extra or partial pulses appear on `sclk`.
- `mosi` changes only on `fall` cycles, or when entering SETUP.
- A `rise` or `fall` arriving the same cycle as the state transition is consumed by the new state's wait condition only if the table above names that state.
- Requirement on the upstream divider: `cnt_val` ≥ 4, so `rise` and `fall` are never adjacent cycles.

## Structure
- Package `adxl362_pkg` holds:
  - `CMD_WRITE` = 8'h0A and `CMD_READ` = 8'h0B.
  - Register addresses `REG_DEVID_AD` = 8'h00, `REG_XDATA` = 8'h08, `REG_POWER_CTL` = 8'h2D.
  - The state enum (IDLE, SETUP, SHIFT, HOLD, GAP).
- One sub-module, `clk_edge_detect`: inputs `in_clk`, `reset`, `sig`; outputs `rise`, `fall`. All other logic lives in the top module.

## Test plan
- Write, `addr` = 0x2D, `wdata` = 0x02, `cnt_val` = 10 → `mosi` carries 0x0A, 0x2D, 0x02 MSB first; exactly 24 `sclk` rises; `sclk` period 10 cycles; one `done` pulse; no `rdata_valid`.
- Read, `addr` = 0x00, `nbytes` = 1, MISO model returns 0xAD → frame 0x0B, 0x00, 0x00; `rdata` = 0xAD with one `rdata_valid` pulse, before `done`.
- Burst read, `addr` = 0x08, `nbytes` = 3, model returns 0x11, 0x22, 0x33 → three `rdata_valid` pulses with those values in order; 40 `sclk` rises; `cs_n` low continuously for the whole frame.
- Read with `nbytes` = 0 → behaves identically to `nbytes` = 1. Separately, `start` pulsed mid-frame → ignored; frame length unchanged.
- `reset` asserted during the address byte → next cycle `cs_n` = 1, `sclk` = 0, `busy` = 0, no `done`. A new write afterwards completes correctly.
- Back-to-back transactions, `start` held high → `cs_n` stays high for at least `cnt_val`/2 cycles between frames.

Source files
------------

// File: rtl/adxl362_pkg.sv
// ============================================================================
// Module   : adxl362_pkg
// Purpose  : Shared constants, FSM state encoding and frame helper for the
//            ADXL362 SPI master.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package adxl362_pkg;

    localparam logic [7:0] CMD_WRITE     = 8'h0A;
    localparam logic [7:0] CMD_READ      = 8'h0B;

    localparam logic [7:0] REG_DEVID_AD  = 8'h00;
    localparam logic [7:0] REG_XDATA     = 8'h08;
    localparam logic [7:0] REG_POWER_CTL = 8'h2D;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_e;

    // Index of the final byte in a frame (0 = command, 1 = address).
    function automatic logic [4:0] frame_last_byte(input logic       is_read,
                                                   input logic [3:0] nbytes,
                                                   input logic [4:0] max_n);
        logic [4:0] n;
        n = {1'b0, nbytes};
        if (n == 5'd0) n = 5'd1;
        if (n > max_n) n = max_n;
        return is_read ? (n + 5'd1) : 5'd2;
    endfunction

endpackage

`default_nettype wire

// File: rtl/clk_edge_detect.sv
// ============================================================================
// Module   : clk_edge_detect
// Purpose  : One-cycle rise/fall strobes from a signal synchronous to in_clk.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_edge_detect (
    input  logic in_clk,
    input  logic reset,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic sig_q;
    logic sig_d;

    always_comb begin
        sig_d = sig;
    end

    always_ff @(posedge in_clk) begin
        if (reset) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign rise = sig  & ~sig_q;
    assign fall = ~sig & sig_q;

endmodule

`default_nettype wire

// File: rtl/adxl362_spi_master.sv
// ============================================================================
// Module   : adxl362_spi_master
// Purpose  : Mode-0 SPI master for the ADXL362: single-byte writes and
//            1..15-byte burst reads, paced by strobes from div_clk.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adxl362_spi_master
    import adxl362_pkg::*;
#(
    parameter int MAX_BYTES = 15
) (
    input  logic       in_clk,
    input  logic       reset,
    input  logic       div_clk,
    input  logic       start,
    input  logic       rw,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    input  logic [3:0] nbytes,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       rdata_valid,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso,
    output logic       cs_n
);

    localparam logic [4:0] MAX_N = 5'(MAX_BYTES);

    logic w_rise;
    logic w_fall;

    clk_edge_detect u_edge (
        .in_clk (in_clk),
        .reset  (reset),
        .sig    (div_clk),
        .rise   (w_rise),
        .fall   (w_fall)
    );

    state_e     state_q,       state_d;
    logic [6:0] tx_q,          tx_d;
    logic [6:0] rx_q,          rx_d;
    logic [2:0] bit_q,         bit_d;
    logic [4:0] byte_q,        byte_d;
    logic [4:0] last_q,        last_d;
    logic       rw_q,          rw_d;
    logic [7:0] addr_q,        addr_d;
    logic [7:0] wdata_q,       wdata_d;
    logic       sclk_q,        sclk_d;
    logic       cs_n_q,        cs_n_d;
    logic       mosi_q,        mosi_d;
    logic       busy_q,        busy_d;
    logic       done_q,        done_d;
    logic [7:0] rdata_q,       rdata_d;
    logic       rdata_valid_q, rdata_valid_d;

    logic [7:0] w_cmd;
    logic [7:0] w_next_byte;
    logic [7:0] w_rx_byte;

    assign w_cmd       = rw ? CMD_READ : CMD_WRITE;
    assign w_next_byte = (byte_q == 5'd0) ? addr_q : (rw_q ? 8'h00 : wdata_q);
    assign w_rx_byte   = {rx_q, miso};

    always_comb begin
        state_d       = state_q;
        tx_d          = tx_q;
        rx_d          = rx_q;
        bit_d         = bit_q;
        byte_d        = byte_q;
        last_d        = last_q;
        rw_d          = rw_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        sclk_d        = sclk_q;
        cs_n_d        = cs_n_q;
        mosi_d        = mosi_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                cs_n_d = 1'b1;
                sclk_d = 1'b0;
                busy_d = 1'b0;
                if (start) begin
                    state_d = SETUP;
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    rw_d    = rw;
                    addr_d  = addr;
                    wdata_d = wdata;
                    last_d  = frame_last_byte(rw, nbytes, MAX_N);
                    mosi_d  = w_cmd[7];
                    tx_d    = w_cmd[6:0];
                    rx_d    = 7'd0;
                    bit_d   = 3'd0;
                    byte_d  = 5'd0;
                end
            end
            SETUP: begin
                if (w_fall) state_d = SHIFT;
            end
            SHIFT: begin
                if (w_rise) begin
                    sclk_d = 1'b1;
                    rx_d   = w_rx_byte[6:0];
                    // Only data bytes of a read produce received bytes.
                    if (bit_q == 3'd7 && rw_q && byte_q >= 5'd2) begin
                        rdata_d       = w_rx_byte;
                        rdata_valid_d = 1'b1;
                    end
                end else if (w_fall) begin
                    sclk_d = 1'b0;
                    bit_d  = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        if (byte_q == last_q) begin
                            state_d = HOLD;
                            mosi_d  = 1'b0;
                        end else begin
                            byte_d = byte_q + 5'd1;
                            mosi_d = w_next_byte[7];
                            tx_d   = w_next_byte[6:0];
                        end
                    end else begin
                        mosi_d = tx_q[6];
                        tx_d   = {tx_q[5:0], 1'b0};
                    end
                end
            end
            HOLD: begin
                sclk_d = 1'b0;
                if (w_rise) begin
                    cs_n_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = GAP;
                end
            end
            GAP: begin
                cs_n_d = 1'b1;
                if (w_fall) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (reset) begin
            state_q       <= IDLE;
            tx_q          <= 7'd0;
            rx_q          <= 7'd0;
            bit_q         <= 3'd0;
            byte_q        <= 5'd0;
            last_q        <= 5'd0;
            rw_q          <= 1'b0;
            addr_q        <= 8'h00;
            wdata_q       <= 8'h00;
            sclk_q        <= 1'b0;
            cs_n_q        <= 1'b1;
            mosi_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            rdata_q       <= 8'h00;
            rdata_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tx_q          <= tx_d;
            rx_q          <= rx_d;
            bit_q         <= bit_d;
            byte_q        <= byte_d;
            last_q        <= last_d;
            rw_q          <= rw_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            sclk_q        <= sclk_d;
            cs_n_q        <= cs_n_d;
            mosi_q        <= mosi_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign sclk        = sclk_q;
    assign mosi        = mosi_q;
    assign cs_n        = cs_n_q;

endmodule

`default_nettype wire

// File: tb/tb_adxl362_spi_master.sv
// ============================================================================
// Module   : tb_adxl362_spi_master
// Purpose  : Self-checking bench for adxl362_spi_master with an SPI slave
//            model and frame-level expectations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adxl362_spi_master;

    logic       in_clk = 1'b0;
    logic       reset;
    logic       div_clk = 1'b0;
    logic       start;
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [3:0] nbytes;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    logic       rdata_valid;
    logic       sclk;
    logic       mosi;
    logic       miso = 1'b0;
    logic       cs_n;

    int total = 0;
    int bad   = 0;

    int cnt_val = 10;
    int div_cnt = 0;

    adxl362_spi_master #(.MAX_BYTES(15)) dut (
        .in_clk      (in_clk),
        .reset       (reset),
        .div_clk     (div_clk),
        .start       (start),
        .rw          (rw),
        .addr        (addr),
        .wdata       (wdata),
        .nbytes      (nbytes),
        .busy        (busy),
        .done        (done),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .sclk        (sclk),
        .mosi        (mosi),
        .miso        (miso),
        .cs_n        (cs_n)
    );

    always #5 in_clk = ~in_clk;

    // Upstream divider: square wave of period cnt_val, synchronous to in_clk.
    always @(posedge in_clk) begin
        if (div_cnt >= cnt_val - 1) div_cnt <= 0;
        else                        div_cnt <= div_cnt + 1;
        div_clk <= (div_cnt < cnt_val / 2);
    end

    // Line monitor and SPI slave (mode 0: shift out after each SCLK fall).
    int         cyc = 0;
    int         rises, done_cnt, csn_rise_cnt, period_err, sclk_bad;
    int         last_rise, valid_cyc, done_cyc;
    int         high_len = 0, last_high_len = 0;
    int         slv_idx = 0;
    logic       sclk_p = 1'b0, cs_n_p = 1'b1;
    bit         mosi_bits[$];
    logic [7:0] rd_q[$];
    bit         slave_bits[0:135];
    logic [7:0] slv_data[0:15];

    always @(negedge in_clk) begin
        cyc++;
        if (sclk && !sclk_p) begin
            rises++;
            mosi_bits.push_back(mosi);
            if (last_rise >= 0 && (cyc - last_rise) != cnt_val) period_err++;
            last_rise = cyc;
        end
        if (!sclk && sclk_p) slv_idx++;
        if (sclk && cs_n) sclk_bad++;
        if (rdata_valid) begin
            rd_q.push_back(rdata);
            valid_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (cs_n && !cs_n_p) csn_rise_cnt++;
        if (cs_n) begin
            high_len++;
            slv_idx = 0;
        end else if (cs_n_p) begin
            last_high_len = high_len;
            high_len      = 0;
        end
        miso   = (slv_idx < 136) ? slave_bits[slv_idx] : 1'b0;
        sclk_p = sclk;
        cs_n_p = cs_n;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        rises        = 0;
        done_cnt     = 0;
        csn_rise_cnt = 0;
        period_err   = 0;
        sclk_bad     = 0;
        last_rise    = -1;
        valid_cyc    = -1;
        done_cyc     = -1;
        mosi_bits.delete();
        rd_q.delete();
    endtask

    function automatic logic [7:0] mosi_byte(input int k);
        logic [7:0] v;
        if (mosi_bits.size() < 8 * (k + 1)) return 8'hxx;
        for (int i = 0; i < 8; i++) v[7-i] = mosi_bits[8*k+i];
        return v;
    endfunction

    // Load the slave with a frame: two don't-care bytes, then slv_data.
    task automatic load_slave(input int n);
        logic [7:0] v;
        for (int b = 0; b < 2 + n; b++) begin
            v = (b < 2) ? 8'($urandom) : slv_data[b-2];
            for (int i = 0; i < 8; i++) slave_bits[b*8+i] = v[7-i];
        end
    endtask

    task automatic wait_idle(output int n, input bit glitch);
        n = 0;
        while (busy && n < 20000) begin
            @(negedge in_clk);
            n++;
            if (glitch && n == 40) start = 1'b1;
            if (glitch && n == 41) start = 1'b0;
        end
    endtask

    task automatic run_frame(input bit r, input logic [7:0] a, input logic [7:0] w,
                             input logic [3:0] nb, input bit glitch, input string nm);
        int         n, waited;
        logic [7:0] exp_tx[$];
        n = r ? ((nb == 4'd0) ? 1 : int'(nb)) : 1;
        exp_tx.push_back(r ? 8'h0B : 8'h0A);
        exp_tx.push_back(a);
        for (int k = 0; k < n; k++) exp_tx.push_back(r ? 8'h00 : w);
        load_slave(n);
        clear_mon();

        rw = r; addr = a; wdata = w; nbytes = nb; start = 1'b1;
        @(negedge in_clk);
        check({nm, "_busy_up"}, {31'd0, busy}, 32'd1);
        check({nm, "_csn_low"}, {31'd0, cs_n}, 32'd0);
        start = 1'b0;
        rw = ~r; addr = 8'($urandom); wdata = 8'($urandom); nbytes = 4'($urandom);
        wait_idle(waited, glitch);
        check({nm, "_timeout"}, {31'd0, (waited < 20000)}, 32'd1);
        repeat (3) @(negedge in_clk);

        check({nm, "_rises"}, rises, 8 * (2 + n));
        check({nm, "_done_cnt"}, done_cnt, 1);
        check({nm, "_csn_rises"}, csn_rise_cnt, 1);
        check({nm, "_period_err"}, period_err, 0);
        check({nm, "_sclk_csn_hi"}, sclk_bad, 0);
        for (int k = 0; k < exp_tx.size(); k++)
            check($sformatf("%s_mosi_b%0d", nm, k), {24'd0, mosi_byte(k)}, {24'd0, exp_tx[k]});
        check({nm, "_rd_cnt"}, rd_q.size(), r ? n : 0);
        if (r) begin
            for (int k = 0; k < n; k++)
                check($sformatf("%s_rdata%0d", nm, k),
                      {24'd0, (k < rd_q.size()) ? rd_q[k] : 8'hxx}, {24'd0, slv_data[k]});
            check({nm, "_valid_before_done"},
                  {31'd0, (valid_cyc >= 0 && valid_cyc < done_cyc)}, 32'd1);
        end
    endtask

    initial begin
        int waited;
        int n_rnd;
        reset = 1'b1; start = 1'b0; rw = 1'b0; addr = 8'h00; wdata = 8'h00; nbytes = 4'd0;
        clear_mon();
        repeat (3) @(negedge in_clk);
        check("rst_cs_n",  {31'd0, cs_n}, 32'd1);
        check("rst_sclk",  {31'd0, sclk}, 32'd0);
        check("rst_mosi",  {31'd0, mosi}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_done",  {31'd0, done}, 32'd0);
        check("rst_rdata", {24'd0, rdata}, 32'd0);
        check("rst_valid", {31'd0, rdata_valid}, 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge in_clk);

        run_frame(1'b0, 8'h2D, 8'h02, 4'd0, 1'b0, "wr_pwr");

        slv_data[0] = 8'hAD;
        run_frame(1'b1, 8'h00, 8'h00, 4'd1, 1'b0, "rd_devid");

        slv_data[0] = 8'h11; slv_data[1] = 8'h22; slv_data[2] = 8'h33;
        run_frame(1'b1, 8'h08, 8'h00, 4'd3, 1'b0, "rd_burst");

        slv_data[0] = 8'h5A;
        run_frame(1'b1, 8'h0E, 8'h00, 4'd0, 1'b1, "rd_nb0_glitch");

        // Reset in the middle of the address byte.
        clear_mon();
        load_slave(1);
        rw = 1'b0; addr = 8'h2D; wdata = 8'h55; start = 1'b1;
        @(negedge in_clk);
        start = 1'b0;
        waited = 0;
        while (rises < 12 && waited < 5000) begin
            @(negedge in_clk);
            waited++;
        end
        check("rst_mid_reach", {31'd0, (rises >= 12 && rises <= 16)}, 32'd1);
        reset = 1'b1;
        @(negedge in_clk);
        check("rst_mid_cs_n", {31'd0, cs_n}, 32'd1);
        check("rst_mid_sclk", {31'd0, sclk}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge in_clk);
        check("rst_mid_no_done", done_cnt, 0);
        repeat (20) @(negedge in_clk);
        run_frame(1'b0, 8'h1F, 8'hC3, 4'd0, 1'b0, "wr_after_rst");

        // Back-to-back frames with start held high.
        clear_mon();
        load_slave(1);
        rw = 1'b0; addr = 8'h2D; wdata = 8'h02; start = 1'b1;
        waited = 0;
        while (done_cnt < 2 && waited < 5000) begin
            @(negedge in_clk);
            waited++;
        end
        start = 1'b0;
        wait_idle(waited, 1'b0);
        repeat (3) @(negedge in_clk);
        check("b2b_done_cnt", done_cnt, 2);
        check("b2b_rises", rises, 48);
        check("b2b_gap", {31'd0, (last_high_len >= cnt_val / 2)}, 32'd1);
        check("b2b_f2_cmd", {24'd0, mosi_byte(3)}, 32'h0A);
        check("b2b_f2_data", {24'd0, mosi_byte(5)}, 32'h02);

        // Randomized frames over several divider ratios.
        for (int t = 0; t < 5; t++) begin
            cnt_val = 4 + 2 * int'($urandom_range(0, 4));
            repeat (30) @(negedge in_clk);
            for (int k = 0; k < 16; k++) slv_data[k] = 8'($urandom);
            n_rnd = int'($urandom_range(0, 15));
            run_frame(1'($urandom), 8'($urandom), 8'($urandom), 4'(n_rnd),
                      1'($urandom), $sformatf("rnd%0d", t));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
